// File: rtl/trap_unit.sv
// trap_unit: exception sequencer between the control unit and the PC register.
//
// Samples prioritised exception requests, redirects the PC to a per-cause vector,
// tracks the handler, and on return reloads the saved PC. A second exception while
// a handler is running is a double fault: the unit parks in HALT until Reset.
//
// Build option: define TRAP_UNIT_NEST_EN to allow one level of nesting. A second
// exception at level 1 saves the current epc/cause on a one-entry stack. A third
// exception, at level 2, is still a double fault.
//
// Ports
//   clk         in   rising-edge clock
//   Reset       in   synchronous, active-high reset
//   exc_req     in   [NCAUSE] exception request lines, bit 0 has the highest priority
//   exc_sample  in   qualifies exc_req for one cycle
//   pc_in       in   [XLEN] PC of the instruction being sampled
//   mret        in   return-from-handler request
//   pc_load     out  one-cycle PC load strobe
//   trap_pc     out  [XLEN] PC to load while pc_load is high, otherwise 0
//   epc_out     out  [XLEN] saved PC of the current trap level
//   cause_out   out  [XLEN] winning index + 1; 0 means no trap
//   busy        out  high in every state except IDLE
//   level       out  [2] current nesting depth
//   nested_err  out  sticky double-fault flag
module trap_unit #(
  parameter int unsigned      XLEN     = 64,
  parameter int unsigned      NCAUSE   = 4,
  parameter logic [XLEN-1:0]  VEC_BASE = 'hFF
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [NCAUSE-1:0] exc_req,
  input  logic              exc_sample,
  input  logic [XLEN-1:0]   pc_in,
  input  logic              mret,
  output logic              pc_load,
  output logic [XLEN-1:0]   trap_pc,
  output logic [XLEN-1:0]   epc_out,
  output logic [XLEN-1:0]   cause_out,
  output logic              busy,
  output logic [1:0]        level,
  output logic              nested_err
);

  typedef enum logic [2:0] {
    StIdle,
    StRedirect,
    StHandler,
    StReturn,
    StHalt
  } state_e;

  state_e          stateQ, stateD;
  logic [XLEN-1:0] epcQ, epcD;
  logic [XLEN-1:0] causeQ, causeD;
  logic [1:0]      levelQ, levelD;
  logic            nestedQ, nestedD;
`ifdef TRAP_UNIT_NEST_EN
  logic [XLEN-1:0] stackEpcQ, stackEpcD;
  logic [XLEN-1:0] stackCauseQ, stackCauseD;
`endif

  logic            excQual;
  logic [XLEN-1:0] winCause;

  assign excQual = exc_sample && (exc_req != '0);

  // Scan from the top so the lowest set index is the one left in winCause.
  always_comb begin
    winCause = '0;
    for (int i = int'(NCAUSE) - 1; i >= 0; i--) begin
      if (exc_req[i]) winCause = XLEN'(i + 1);
    end
  end

  // State register and trap context.
  always_ff @(posedge clk) begin
    if (Reset) begin
      stateQ      <= StIdle;
      epcQ        <= '0;
      causeQ      <= '0;
      levelQ      <= '0;
      nestedQ     <= 1'b0;
`ifdef TRAP_UNIT_NEST_EN
      stackEpcQ   <= '0;
      stackCauseQ <= '0;
`endif
    end else begin
      stateQ      <= stateD;
      epcQ        <= epcD;
      causeQ      <= causeD;
      levelQ      <= levelD;
      nestedQ     <= nestedD;
`ifdef TRAP_UNIT_NEST_EN
      stackEpcQ   <= stackEpcD;
      stackCauseQ <= stackCauseD;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    stateD      = stateQ;
    epcD        = epcQ;
    causeD      = causeQ;
    levelD      = levelQ;
    nestedD     = nestedQ;
`ifdef TRAP_UNIT_NEST_EN
    stackEpcD   = stackEpcQ;
    stackCauseD = stackCauseQ;
`endif
    unique case (stateQ)
      StIdle: begin
        if (excQual) begin
          epcD   = pc_in;
          causeD = winCause;
          levelD = 2'd1;
          stateD = StRedirect;
        end
      end
      StRedirect: stateD = StHandler;
      StHandler: begin
        // An exception takes precedence over a simultaneous mret.
        if (excQual) begin
`ifdef TRAP_UNIT_NEST_EN
          if (levelQ == 2'd1) begin
            stackEpcD   = epcQ;
            stackCauseD = causeQ;
            epcD        = pc_in;
            causeD      = winCause;
            levelD      = 2'd2;
            stateD      = StRedirect;
          end else begin
            nestedD = 1'b1;
            stateD  = StHalt;
          end
`else
          nestedD = 1'b1;
          stateD  = StHalt;
`endif
        end else if (mret) begin
          stateD = StReturn;
        end
      end
      StReturn: begin
`ifdef TRAP_UNIT_NEST_EN
        if (levelQ == 2'd2) begin
          epcD   = stackEpcQ;
          causeD = stackCauseQ;
          levelD = 2'd1;
          stateD = StHandler;
        end else begin
          epcD   = '0;
          causeD = '0;
          levelD = '0;
          stateD = StIdle;
        end
`else
        epcD   = '0;
        causeD = '0;
        levelD = '0;
        stateD = StIdle;
`endif
      end
      StHalt: stateD = StHalt;
      default: stateD = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    pc_load = 1'b0;
    trap_pc = '0;
    unique case (stateQ)
      StRedirect: begin
        pc_load = 1'b1;
        trap_pc = VEC_BASE - (causeQ - XLEN'(1));
      end
      StReturn: begin
        pc_load = 1'b1;
        trap_pc = epcQ;
      end
      default: begin
        pc_load = 1'b0;
        trap_pc = '0;
      end
    endcase
  end

  assign busy       = (stateQ != StIdle);
  assign epc_out    = epcQ;
  assign cause_out  = causeQ;
  assign level      = levelQ;
  assign nested_err = nestedQ;

endmodule

// File: tb/tb_trap_unit.sv
// Directed bench for trap_unit. Inputs change 1 ns after a rising edge and outputs
// are sampled at the same point, so each check sees the state after that edge.
module tb_trap_unit;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned NCAUSE = 4;

  logic              clk;
  logic              Reset;
  logic [NCAUSE-1:0] exc_req;
  logic              exc_sample;
  logic [XLEN-1:0]   pc_in;
  logic              mret;
  logic              pc_load;
  logic [XLEN-1:0]   trap_pc;
  logic [XLEN-1:0]   epc_out;
  logic [XLEN-1:0]   cause_out;
  logic              busy;
  logic [1:0]        level;
  logic              nested_err;

  int checks = 0;
  int errors = 0;

  trap_unit #(
    .XLEN     (XLEN),
    .NCAUSE   (NCAUSE),
    .VEC_BASE (64'hFF)
  ) dut (
    .clk        (clk),
    .Reset      (Reset),
    .exc_req    (exc_req),
    .exc_sample (exc_sample),
    .pc_in      (pc_in),
    .mret       (mret),
    .pc_load    (pc_load),
    .trap_pc    (trap_pc),
    .epc_out    (epc_out),
    .cause_out  (cause_out),
    .busy       (busy),
    .level      (level),
    .nested_err (nested_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    exc_req    = '0;
    exc_sample = 1'b0;
    mret       = 1'b0;
    pc_in      = '0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
  endtask

  // Raise one exception from IDLE; returns with the DUT in REDIRECT.
  task automatic raise(input logic [NCAUSE-1:0] req, input logic [XLEN-1:0] pc);
    exc_req    = req;
    exc_sample = 1'b1;
    pc_in      = pc;
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    // Reset wins over a simultaneous exception.
    Reset      = 1'b1;
    exc_req    = 4'b0001;
    exc_sample = 1'b1;
    pc_in      = 64'h1234;
    mret       = 1'b1;
    step();
    step();
    Reset = 1'b0;
    idle_inputs();
    checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL rst_pc_load got %0h want 0", pc_load); end
    checks++; if (trap_pc !== '0) begin errors++; $display("FAIL rst_trap_pc got %0h want 0", trap_pc); end
    checks++; if (epc_out !== '0) begin errors++; $display("FAIL rst_epc got %0h want 0", epc_out); end
    checks++; if (cause_out !== '0) begin errors++; $display("FAIL rst_cause got %0h want 0", cause_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0h want 0", busy); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL rst_level got %0h want 0", level); end
    checks++; if (nested_err !== 1'b0) begin errors++; $display("FAIL rst_nested got %0h want 0", nested_err); end
  endtask

  task automatic test_cause3();
    raise(4'b0100, 64'h40);
    checks++; if (pc_load !== 1'b1) begin errors++; $display("FAIL c3_pc_load got %0h want 1", pc_load); end
    checks++; if (trap_pc !== 64'hFD) begin errors++; $display("FAIL c3_trap_pc got %0h want fd", trap_pc); end
    checks++; if (cause_out !== 64'd3) begin errors++; $display("FAIL c3_cause got %0h want 3", cause_out); end
    checks++; if (epc_out !== 64'h40) begin errors++; $display("FAIL c3_epc got %0h want 40", epc_out); end
    checks++; if (level !== 2'd1) begin errors++; $display("FAIL c3_level got %0h want 1", level); end
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL c3_handler_busy got %0h want 1", busy); end
    checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL c3_handler_pc_load got %0h want 0", pc_load); end
    checks++; if (trap_pc !== '0) begin errors++; $display("FAIL c3_handler_trap_pc got %0h want 0", trap_pc); end
    mret = 1'b1;
    step();
    mret = 1'b0;
    checks++; if (pc_load !== 1'b1) begin errors++; $display("FAIL c3_ret_pc_load got %0h want 1", pc_load); end
    checks++; if (trap_pc !== 64'h40) begin errors++; $display("FAIL c3_ret_trap_pc got %0h want 40", trap_pc); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL c3_idle_busy got %0h want 0", busy); end
  endtask

  task automatic test_cause2_return();
    raise(4'b1010, 64'h40);
    checks++; if (cause_out !== 64'd2) begin errors++; $display("FAIL c2_cause got %0h want 2", cause_out); end
    checks++; if (trap_pc !== 64'hFE) begin errors++; $display("FAIL c2_trap_pc got %0h want fe", trap_pc); end
    step();
    mret = 1'b1;
    step();
    mret = 1'b0;
    checks++; if (pc_load !== 1'b1) begin errors++; $display("FAIL c2_ret_pc_load got %0h want 1", pc_load); end
    checks++; if (trap_pc !== 64'h40) begin errors++; $display("FAIL c2_ret_trap_pc got %0h want 40", trap_pc); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL c2_idle_busy got %0h want 0", busy); end
    checks++; if (cause_out !== '0) begin errors++; $display("FAIL c2_idle_cause got %0h want 0", cause_out); end
    checks++; if (epc_out !== '0) begin errors++; $display("FAIL c2_idle_epc got %0h want 0", epc_out); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL c2_idle_level got %0h want 0", level); end
  endtask

  task automatic test_ignored();
    // mret and an empty sample in IDLE do nothing.
    mret       = 1'b1;
    exc_sample = 1'b1;
    exc_req    = '0;
    pc_in      = 64'h99;
    step();
    idle_inputs();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_idle_busy got %0h want 0", busy); end
    checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL ign_idle_pc_load got %0h want 0", pc_load); end
    // A highest-priority request during REDIRECT is dropped.
    raise(4'b1000, 64'h200);
    checks++; if (trap_pc !== 64'hFC) begin errors++; $display("FAIL ign_c4_trap_pc got %0h want fc", trap_pc); end
    exc_req    = 4'b0001;
    exc_sample = 1'b1;
    pc_in      = 64'h300;
    mret       = 1'b1;
    step();
    idle_inputs();
    checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL ign_redir_pc_load got %0h want 0", pc_load); end
    checks++; if (cause_out !== 64'd4) begin errors++; $display("FAIL ign_redir_cause got %0h want 4", cause_out); end
    checks++; if (epc_out !== 64'h200) begin errors++; $display("FAIL ign_redir_epc got %0h want 200", epc_out); end
    // Empty sample in HANDLER does nothing either.
    exc_sample = 1'b1;
    step();
    idle_inputs();
    checks++; if (nested_err !== 1'b0 || pc_load !== 1'b0) begin
      errors++; $display("FAIL ign_handler_empty got nested %0h pc_load %0h want 0 0", nested_err, pc_load);
    end
    mret = 1'b1;
    step();
    // mret during RETURN is dropped; the unit still goes IDLE.
    step();
    mret = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_ret_busy got %0h want 0", busy); end
  endtask

  task automatic test_nested();
    raise(4'b0100, 64'h40);
    step();
    exc_req    = 4'b0001;
    exc_sample = 1'b1;
    pc_in      = 64'h80;
    step();
    idle_inputs();
`ifdef TRAP_UNIT_NEST_EN
    checks++; if (pc_load !== 1'b1) begin errors++; $display("FAIL nest_pc_load got %0h want 1", pc_load); end
    checks++; if (trap_pc !== 64'hFF) begin errors++; $display("FAIL nest_trap_pc got %0h want ff", trap_pc); end
    checks++; if (level !== 2'd2) begin errors++; $display("FAIL nest_level got %0h want 2", level); end
    checks++; if (epc_out !== 64'h80) begin errors++; $display("FAIL nest_epc got %0h want 80", epc_out); end
    step();
    mret = 1'b1;
    step();
    mret = 1'b0;
    checks++; if (trap_pc !== 64'h80) begin errors++; $display("FAIL nest_ret2_trap_pc got %0h want 80", trap_pc); end
    step();
    checks++; if (level !== 2'd1) begin errors++; $display("FAIL nest_pop_level got %0h want 1", level); end
    checks++; if (epc_out !== 64'h40) begin errors++; $display("FAIL nest_pop_epc got %0h want 40", epc_out); end
    checks++; if (cause_out !== 64'd3) begin errors++; $display("FAIL nest_pop_cause got %0h want 3", cause_out); end
    mret = 1'b1;
    step();
    mret = 1'b0;
    checks++; if (trap_pc !== 64'h40) begin errors++; $display("FAIL nest_ret1_trap_pc got %0h want 40", trap_pc); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nest_idle_busy got %0h want 0", busy); end
`else
    checks++; if (nested_err !== 1'b1) begin errors++; $display("FAIL halt_nested got %0h want 1", nested_err); end
    checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL halt_pc_load got %0h want 0", pc_load); end
    checks++; if (level !== 2'd1) begin errors++; $display("FAIL halt_level got %0h want 1", level); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL halt_busy got %0h want 1", busy); end
    mret = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL halt_mret_pc_load[%0d] got %0h want 0", i, pc_load); end
    end
    mret = 1'b0;
    do_reset();
    checks++; if (nested_err !== 1'b0) begin errors++; $display("FAIL halt_reset_nested got %0h want 0", nested_err); end
`endif
  endtask

  task automatic test_reset_mid_and_priority();
    raise(4'b0010, 64'h500);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL midrst_pc_load got %0h want 0", pc_load); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %0h want 0", busy); end
    checks++; if (cause_out !== '0) begin errors++; $display("FAIL midrst_cause got %0h want 0", cause_out); end
    raise(4'b0010, 64'h500);
    checks++; if (trap_pc !== 64'hFE) begin errors++; $display("FAIL after_rst_trap_pc got %0h want fe", trap_pc); end
    step();
    exc_req    = 4'b0100;
    exc_sample = 1'b1;
    pc_in      = 64'h600;
    mret       = 1'b1;
    step();
    idle_inputs();
`ifdef TRAP_UNIT_NEST_EN
    checks++; if (pc_load !== 1'b1 || trap_pc !== 64'hFD) begin
      errors++; $display("FAIL prio_redirect got pc_load %0h trap_pc %0h want 1 fd", pc_load, trap_pc);
    end
`else
    checks++; if (nested_err !== 1'b1 || pc_load !== 1'b0) begin
      errors++; $display("FAIL prio_halt got nested %0h pc_load %0h want 1 0", nested_err, pc_load);
    end
`endif
    do_reset();
    checks++; if (busy !== 1'b0 || level !== 2'd0) begin
      errors++; $display("FAIL final_reset got busy %0h level %0h want 0 0", busy, level);
    end
  endtask

  initial begin
    Reset = 1'b0;
    idle_inputs();
    test_reset();
    test_cause3();
    test_cause2_return();
    test_ignored();
    test_nested();
    test_reset_mid_and_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
